acorn_crypt_stream: RTL

ACORN_CRYPT_STREAM -- requirements
Module: acorn_crypt_stream

---
 rtl/acorn_pkg.sv | 16 +
 rtl/acorn_step.sv | 36 +++
 rtl/acorn_crypt_stream.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/acorn_pkg.sv
// Shared constants, FSM encoding and boolean helpers for the ACORN-128 stream engine.
package acorn_pkg;
    localparam int STATE_W      = 293;
    localparam int PAD_STEPS    = 256;
    localparam int PAD_CA_STEPS = 128;

    typedef enum logic [2:0] {IDLE, DATA, STEP, OUTW, PAD, DONE} fsm_state_e;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction
endpackage

// File: rtl/acorn_step.sv
// One combinational ACORN-128 step: LFSR mixing, keystream bit, feedback and shift.
module acorn_step
    import acorn_pkg::*;
(
    input  logic [STATE_W-1:0] s,
    input  logic               ca,
    input  logic               cb,
    input  logic               din,
    input  logic               decrypt,
    output logic [STATE_W-1:0] s_next,
    output logic               ks,
    output logic               dout
);
    logic [STATE_W-1:0] t;
    logic               f;
    logic               m;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        t = s;
        // All six taps read pre-update values, matching the in-place order of the reference.
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];

        ks   = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
        dout = din ^ ks;
        m    = decrypt ? dout : din;
        f    = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);

        s_next = {f ^ m, t[STATE_W-1:1]};
    end
endmodule

// File: rtl/acorn_crypt_stream.sv
// ACORN-128 encrypt/decrypt data phase plus 256-step padding, U steps per clock.
module acorn_crypt_stream
    import acorn_pkg::*;
#(
    parameter int DW = 32,
    parameter int U  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    decrypt,
    input  logic                    empty_msg,
    input  logic [STATE_W-1:0]      state_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_last,
    input  logic [$clog2(DW/8):0]   in_bytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic                    busy,
    output logic                    done,
    output logic [STATE_W-1:0]      state_out
);
    localparam int NB    = DW / 8;
    localparam int BW    = $clog2(NB) + 1;
    localparam int MAXL  = (DW > PAD_STEPS) ? DW : PAD_STEPS;
    localparam int CNT_W = $clog2(MAXL + U + 1);

    fsm_state_e         state_q;
    logic [STATE_W-1:0] s_q;
    logic [STATE_W-1:0] state_out_q;
    logic               dec_q;
    logic               last_q;
    logic [DW-1:0]      data_q;
    logic [DW-1:0]      out_q;
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_pad;
    logic               dec_step;
    logic [CNT_W-1:0]   limit;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               fin;
    logic [DW-1:0]      data_sh;
    logic [U-1:0]       ob;
    logic [U-1:0]       ks_v;
    logic [DW-1:0]      ob_w;
    logic [DW-1:0]      out_nxt;
    logic [BW-1:0]      nb_eff;
    logic               unused_ks;

    assign in_pad   = (state_q == PAD);
    assign dec_step = (state_q == STEP) & dec_q;
    assign limit    = in_pad ? CNT_W'(PAD_STEPS) : total_q;
    assign cnt_nxt  = cnt_q + CNT_W'(U);
    assign fin      = (cnt_nxt >= limit);
    assign data_sh  = data_q >> cnt_q;

    // Stage k handles step cnt_q+k; stages past the limit pass the state through untouched.
    for (genvar k = 0; k < U; k++) begin : g_step
        logic [STATE_W-1:0] s_prev;
        logic [STATE_W-1:0] s_new;
        logic [STATE_W-1:0] s_o;
        logic [CNT_W-1:0]   idx;
        logic               en;
        logic               din;
        logic               ca;
        logic               dout_k;

        if (k == 0) begin : g_first
            assign s_prev = s_q;
        end else begin : g_chain
            assign s_prev = g_step[k-1].s_o;
        end

        assign idx = cnt_q + CNT_W'(k);
        assign en  = (idx < limit);
        assign din = in_pad ? (idx == '0) : data_sh[k];
        assign ca  = in_pad ? (idx < CNT_W'(PAD_CA_STEPS)) : 1'b1;

        acorn_step u_step (
            .s       (s_prev),
            .ca      (ca),
            .cb      (1'b0),
            .din     (din),
            .decrypt (dec_step),
            .s_next  (s_new),
            .ks      (ks_v[k]),
            .dout    (dout_k)
        );

        assign s_o   = en ? s_new : s_prev;
        assign ob[k] = en & dout_k;
    end

    assign unused_ks = ^ks_v;

    always_comb begin
        ob_w         = '0;
        ob_w[U-1:0]  = ob;
        out_nxt      = out_q | (ob_w << cnt_q);
        nb_eff       = BW'(NB);
        if (in_last && (in_bytes != '0) && (in_bytes <= BW'(NB)))
            nb_eff = in_bytes;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            state_out_q <= '0;
            dec_q       <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            out_q       <= '0;
            total_q     <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    s_q     <= state_in;
                    dec_q   <= decrypt;
                    cnt_q   <= '0;
                    state_q <= empty_msg ? PAD : DATA;
                end
                DATA: if (in_valid) begin
                    data_q  <= in_data;
                    last_q  <= in_last;
                    total_q <= CNT_W'(nb_eff) << 3;
                    out_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= STEP;
                end
                STEP: begin
                    s_q   <= g_step[U-1].s_o;
                    out_q <= out_nxt;
                    if (fin) begin
                        cnt_q   <= '0;
                        state_q <= OUTW;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
                OUTW: if (out_ready) state_q <= last_q ? PAD : DATA;
                PAD: begin
                    s_q <= g_step[U-1].s_o;
                    if (fin) begin
                        cnt_q       <= '0;
                        state_out_q <= g_step[U-1].s_o;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == DATA);
    assign out_valid = (state_q == OUTW);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_data  = out_q;
    assign state_out = state_out_q;
endmodule
